// File: rtl/mprj_io_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module      : mprj_io_cfg_loader
// Description : Serially loads one CFG_BITS word per user-project IO pad into
//               two pad-control shift chains (area 1 and area 2), then pulses
//               a parallel-load strobe so every pad latches its new settings
//               at the same time.
// Revision    : 1.0 - initial release
// ============================================================================
module mprj_io_cfg_loader #(
    parameter int AREA1PADS  = 19,
    parameter int TOTAL_PADS = 38,
    parameter int CFG_BITS   = 13,
    parameter int CLK_DIV    = 2
) (
    input  logic                           wb_clk_i,
    input  logic                           wb_rst_i,
    input  logic                           xfer_start,
    input  logic                           xfer_init,
    input  logic [TOTAL_PADS*CFG_BITS-1:0] cfg_words,
    output logic                           busy,
    output logic                           done,
    output logic                           serial_clock,
    output logic                           serial_load,
    output logic                           serial_resetn,
    output logic                           serial_data_1,
    output logic                           serial_data_2
);

    // Chain geometry: the shorter chain is front-padded with zero words so
    // both chains finish shifting on the same serial clock edge.
    localparam int c_N1 = AREA1PADS;
    localparam int c_N2 = TOTAL_PADS - AREA1PADS;
    localparam int c_M  = (c_N1 > c_N2) ? c_N1 : c_N2;
    localparam int c_WW = (c_M > 1) ? $clog2(c_M) : 1;
    localparam int c_BW = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
    localparam int c_PW = $clog2(2 * CLK_DIV);
    localparam int c_IW = $clog2(TOTAL_PADS * CFG_BITS);

    localparam logic [2:0] c_IDLE       = 3'd0;
    localparam logic [2:0] c_INIT       = 3'd1;
    localparam logic [2:0] c_SHIFT_LO   = 3'd2;
    localparam logic [2:0] c_SHIFT_HI   = 3'd3;
    localparam logic [2:0] c_LOAD_SETUP = 3'd4;
    localparam logic [2:0] c_LOAD       = 3'd5;
    localparam logic [2:0] c_DONE       = 3'd6;

    logic [2:0]      r_state;
    logic [c_PW-1:0] r_phase;
    logic [c_WW-1:0] r_word;
    logic [c_BW-1:0] r_bit;
    logic            r_busy;
    logic            r_done;
    logic            r_sclk;
    logic            r_load;
    logic            r_resetn;
    logic            r_d1;
    logic            r_d2;

    logic            w_phase_end;
    logic            w_init_end;
    logic            w_bit_last;
    logic            w_xfer_last;
    logic [c_BW-1:0] w_adv_bit;
    logic [c_WW-1:0] w_adv_word;
    logic [c_BW-1:0] w_sel_bit;
    logic [c_WW-1:0] w_sel_word;
    logic            w_pad1_valid;
    logic            w_pad2_valid;
    logic [c_IW-1:0] w_idx1;
    logic [c_IW-1:0] w_idx2;
    logic            w_bit1;
    logic            w_bit2;

    assign w_phase_end = (r_phase == c_PW'(CLK_DIV - 1));
    assign w_init_end  = (r_phase == c_PW'(2 * CLK_DIV - 1));
    assign w_bit_last  = (r_bit == c_BW'(CFG_BITS - 1));
    assign w_xfer_last = w_bit_last && (r_word == c_WW'(c_M - 1));
    assign w_adv_bit   = w_bit_last ? '0 : r_bit + c_BW'(1);
    assign w_adv_word  = w_bit_last ? r_word + c_WW'(1) : r_word;

    // Data is registered on entry to SHIFT_LO; coming from SHIFT_HI that is
    // the next bit, otherwise (IDLE/INIT) the counters already point at bit 0.
    assign w_sel_bit  = (r_state == c_SHIFT_HI) ? w_adv_bit  : r_bit;
    assign w_sel_word = (r_state == c_SHIFT_HI) ? w_adv_word : r_word;

    // Chain 1 sends its highest pad first; chain 2 its lowest pad first.
    assign w_pad1_valid = (int'(w_sel_word) >= c_M - c_N1);
    assign w_pad2_valid = (int'(w_sel_word) >= c_M - c_N2);
    assign w_idx1 = c_IW'((c_M - 1 - int'(w_sel_word)) * CFG_BITS
                          + (CFG_BITS - 1 - int'(w_sel_bit)));
    assign w_idx2 = c_IW'((TOTAL_PADS - c_M + int'(w_sel_word)) * CFG_BITS
                          + (CFG_BITS - 1 - int'(w_sel_bit)));
    assign w_bit1 = w_pad1_valid & cfg_words[w_idx1];
    assign w_bit2 = w_pad2_valid & cfg_words[w_idx2];

    // Sequencer: state, phase timing, bit/word counters and registered outputs
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state  <= c_IDLE;
            r_phase  <= '0;
            r_word   <= '0;
            r_bit    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_sclk   <= 1'b0;
            r_load   <= 1'b0;
            r_resetn <= 1'b0;
            r_d1     <= 1'b0;
            r_d2     <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_resetn <= 1'b1;
            case (r_state)
                c_IDLE: begin
                    // The cycle showing done is still part of the transfer.
                    if (xfer_start && !r_done) begin
                        r_busy  <= 1'b1;
                        r_word  <= '0;
                        r_bit   <= '0;
                        r_phase <= '0;
                        if (xfer_init) begin
                            r_state  <= c_INIT;
                            r_resetn <= 1'b0;
                        end else begin
                            r_state <= c_SHIFT_LO;
                            r_d1    <= w_bit1;
                            r_d2    <= w_bit2;
                        end
                    end
                end
                c_INIT: begin
                    if (w_init_end) begin
                        r_phase <= '0;
                        r_state <= c_SHIFT_LO;
                        r_d1    <= w_bit1;
                        r_d2    <= w_bit2;
                    end else begin
                        r_phase  <= r_phase + c_PW'(1);
                        r_resetn <= 1'b0;
                    end
                end
                c_SHIFT_LO: begin
                    if (w_phase_end) begin
                        r_phase <= '0;
                        r_state <= c_SHIFT_HI;
                        r_sclk  <= 1'b1;
                    end else begin
                        r_phase <= r_phase + c_PW'(1);
                    end
                end
                c_SHIFT_HI: begin
                    if (w_phase_end) begin
                        r_phase <= '0;
                        r_sclk  <= 1'b0;
                        if (w_xfer_last) begin
                            r_state <= c_LOAD_SETUP;
                            r_d1    <= 1'b0;
                            r_d2    <= 1'b0;
                        end else begin
                            r_state <= c_SHIFT_LO;
                            r_bit   <= w_adv_bit;
                            r_word  <= w_adv_word;
                            r_d1    <= w_bit1;
                            r_d2    <= w_bit2;
                        end
                    end else begin
                        r_phase <= r_phase + c_PW'(1);
                    end
                end
                c_LOAD_SETUP: begin
                    if (w_phase_end) begin
                        r_phase <= '0;
                        r_state <= c_LOAD;
                        r_load  <= 1'b1;
                    end else begin
                        r_phase <= r_phase + c_PW'(1);
                    end
                end
                c_LOAD: begin
                    if (w_phase_end) begin
                        r_phase <= '0;
                        r_state <= c_DONE;
                        r_load  <= 1'b0;
                    end else begin
                        r_phase <= r_phase + c_PW'(1);
                    end
                end
                c_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_word  <= '0;
                    r_bit   <= '0;
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                    r_phase <= '0;
                    r_busy  <= 1'b0;
                    r_sclk  <= 1'b0;
                    r_load  <= 1'b0;
                    r_d1    <= 1'b0;
                    r_d2    <= 1'b0;
                end
            endcase
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign serial_clock  = r_sclk;
    assign serial_load   = r_load;
    assign serial_resetn = r_resetn;
    assign serial_data_1 = r_d1;
    assign serial_data_2 = r_d2;

endmodule
`default_nettype wire

// File: tb/tb_mprj_io_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_mprj_io_cfg_loader
// Description : Self-checking bench for mprj_io_cfg_loader. Three instances
//               (small padded, default size, balanced chains) are checked
//               every cycle against a per-cycle output schedule built from
//               the transfer rules, plus literal expectations per scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mprj_io_cfg_loader;

    // {busy, done, serial_clock, serial_load, serial_resetn, data_1, data_2}
    typedef logic [6:0] vec_t;
    typedef vec_t vq_t[$];

    localparam vec_t c_RST_V  = 7'b0000000;
    localparam vec_t c_IDLE_V = 7'b0000100;

    localparam int c_P_T  [3] = '{6, 38, 6};
    localparam int c_P_A  [3] = '{4, 19, 3};
    localparam int c_P_CB [3] = '{4, 13, 4};
    localparam int c_P_D  [3] = '{1, 2, 1};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_v [3];
    logic         init_v  [3];
    logic [511:0] cfg_v   [3];
    logic         o_busy  [3];
    logic         o_done  [3];
    logic         o_sclk  [3];
    logic         o_load  [3];
    logic         o_rstn  [3];
    logic         o_d1    [3];
    logic         o_d2    [3];
    vec_t         out_v   [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mprj_io_cfg_loader #(.AREA1PADS(4), .TOTAL_PADS(6), .CFG_BITS(4), .CLK_DIV(1)) u_dut_a (
        .wb_clk_i(clk), .wb_rst_i(rst), .xfer_start(start_v[0]), .xfer_init(init_v[0]),
        .cfg_words(cfg_v[0][23:0]), .busy(o_busy[0]), .done(o_done[0]),
        .serial_clock(o_sclk[0]), .serial_load(o_load[0]), .serial_resetn(o_rstn[0]),
        .serial_data_1(o_d1[0]), .serial_data_2(o_d2[0]));

    mprj_io_cfg_loader u_dut_b (
        .wb_clk_i(clk), .wb_rst_i(rst), .xfer_start(start_v[1]), .xfer_init(init_v[1]),
        .cfg_words(cfg_v[1][493:0]), .busy(o_busy[1]), .done(o_done[1]),
        .serial_clock(o_sclk[1]), .serial_load(o_load[1]), .serial_resetn(o_rstn[1]),
        .serial_data_1(o_d1[1]), .serial_data_2(o_d2[1]));

    mprj_io_cfg_loader #(.AREA1PADS(3), .TOTAL_PADS(6), .CFG_BITS(4), .CLK_DIV(1)) u_dut_c (
        .wb_clk_i(clk), .wb_rst_i(rst), .xfer_start(start_v[2]), .xfer_init(init_v[2]),
        .cfg_words(cfg_v[2][23:0]), .busy(o_busy[2]), .done(o_done[2]),
        .serial_clock(o_sclk[2]), .serial_load(o_load[2]), .serial_resetn(o_rstn[2]),
        .serial_data_1(o_d1[2]), .serial_data_2(o_d2[2]));

    for (genvar gi = 0; gi < 3; gi++) begin : g_out
        assign out_v[gi] = {o_busy[gi], o_done[gi], o_sclk[gi], o_load[gi],
                            o_rstn[gi], o_d1[gi], o_d2[gi]};
    end

    // Full per-cycle output schedule of one transfer, starting with the cycle
    // right after the edge that accepts xfer_start.
    function automatic vq_t build(input int t, input int a, input int cb, input int d,
                                  input logic init, input logic [511:0] cfg);
        vq_t  r;
        int   n1, n2, m, w, bi;
        logic b1, b2;
        n1 = a;
        n2 = t - a;
        m  = (n1 > n2) ? n1 : n2;
        r  = {};
        if (init) for (int k = 0; k < 2 * d; k++) r.push_back(7'b1000000);
        for (int k = 0; k < m * cb; k++) begin
            w  = k / cb;
            bi = cb - 1 - (k % cb);
            b1 = (w >= m - n1) ? cfg[9'((n1 - 1 - (w - (m - n1))) * cb + bi)] : 1'b0;
            b2 = (w >= m - n2) ? cfg[9'((a + (w - (m - n2))) * cb + bi)] : 1'b0;
            for (int j = 0; j < d; j++) r.push_back({5'b10001, b1, b2});
            for (int j = 0; j < d; j++) r.push_back({5'b10101, b1, b2});
        end
        for (int j = 0; j < d; j++) r.push_back(7'b1000100);
        for (int j = 0; j < d; j++) r.push_back(7'b1001100);
        r.push_back(7'b1000100);
        r.push_back(7'b0100100);
        return r;
    endfunction

    // Model: a start is accepted only when no schedule is pending and the
    // previous cycle was not the done cycle.
    vq_t  q     [3];
    vec_t exp_v [3];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                q[i].delete();
                exp_v[i] = c_RST_V;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (q[i].size() == 0 && exp_v[i][5] == 1'b0 && start_v[i] === 1'b1)
                    q[i] = build(c_P_T[i], c_P_A[i], c_P_CB[i], c_P_D[i], init_v[i], cfg_v[i]);
                if (q[i].size() != 0) exp_v[i] = q[i].pop_front();
                else                  exp_v[i] = c_IDLE_V;
            end
        end
    end

    // Every-cycle comparison of all three instances against the model
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (out_v[i] !== exp_v[i]) begin
                    n_fail++;
                    $display("FAIL model_trace dut=%0d t=%0t got=%b want=%b",
                             i, $time, out_v[i], exp_v[i]);
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=0x%0h want=0x%0h", name, got, want);
        end
    endtask

    // Runs one transfer on instance i and measures it from the sampling edge.
    task automatic run_xfer(input int i, input logic init, output int rises,
                            output int ones1, output int ones2,
                            output logic [31:0] s1, output logic [31:0] s2,
                            output int done_t, output int load_w,
                            output int rstn_low, output int busy_at_done);
        vec_t o, p;
        rises = 0; ones1 = 0; ones2 = 0; s1 = '0; s2 = '0;
        done_t = -1; load_w = 0; rstn_low = 0; busy_at_done = 1;
        @(negedge clk);
        start_v[i] = 1'b1;
        init_v[i]  = init;
        @(posedge clk);
        #1 start_v[i] = 1'b0;
        p = '0;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            o = out_v[i];
            if (o[4] && !p[4]) begin
                rises++;
                s1 = {s1[30:0], o[1]};
                s2 = {s2[30:0], o[0]};
                if (o[1]) ones1++;
                if (o[0]) ones2++;
            end
            if (o[3]) load_w++;
            if (!o[2]) rstn_low++;
            p = o;
            if (o[5]) begin
                done_t = t;
                busy_at_done = int'(o[6]);
                break;
            end
        end
        chk("xfer_done_seen", (done_t >= 0) ? 1 : 0, 1);
    endtask

    int          rises, ones1, ones2, done_t, load_w, rstn_low, busy_at_done, cnt;
    logic [31:0] s1, s2;
    vec_t        o, p;

    initial begin
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            init_v[i]  = 1'b0;
        end
        cfg_v[0] = 512'h654321;
        cfg_v[1] = '1;
        cfg_v[2] = 512'h654321;

        #2;
        for (int i = 0; i < 3; i++) chk("reset_outputs", int'(out_v[i]), 0);
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk("idle_after_release", int'(out_v[i]), 4);

        // Padded chain 2, no init
        run_xfer(0, 1'b0, rises, ones1, ones2, s1, s2, done_t, load_w, rstn_low, busy_at_done);
        chk("s1_rises", rises, 16);
        chk("s1_data1", s1, 32'h4321);
        chk("s1_data2", s2, 32'h0056);
        chk("s1_done_cycle", done_t, 35);
        chk("s1_load_width", load_w, 1);
        chk("s1_busy_at_done", busy_at_done, 0);
        chk("s1_resetn_low", rstn_low, 0);

        // Same with chain reset first (started on the cycle after done)
        run_xfer(0, 1'b1, rises, ones1, ones2, s1, s2, done_t, load_w, rstn_low, busy_at_done);
        chk("s2_resetn_low", rstn_low, 2);
        chk("s2_done_cycle", done_t, 37);
        chk("s2_data1", s1, 32'h4321);

        // Default geometry, all ones
        run_xfer(1, 1'b0, rises, ones1, ones2, s1, s2, done_t, load_w, rstn_low, busy_at_done);
        chk("s3_rises", rises, 247);
        chk("s3_ones1", ones1, 247);
        chk("s3_ones2", ones2, 247);
        chk("s3_done_cycle", done_t, 993);
        chk("s3_load_width", load_w, 2);

        // Balanced chains: no padding
        run_xfer(2, 1'b0, rises, ones1, ones2, s1, s2, done_t, load_w, rstn_low, busy_at_done);
        chk("s6_rises", rises, 12);
        chk("s6_data1", s1, 32'h321);
        chk("s6_data2", s2, 32'h456);
        chk("s6_done_cycle", done_t, 27);

        // Starts during SHIFT_HI and during the done cycle are ignored
        @(negedge clk);
        start_v[0] = 1'b1;
        init_v[0]  = 1'b0;
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        cnt = 0;
        while (out_v[0][4] !== 1'b1 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        chk("s4_shift_hi_seen", int'(out_v[0][4]), 1);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        cnt = 0;
        while (out_v[0][5] !== 1'b1 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        chk("s4_first_done_seen", int'(out_v[0][5]), 1);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        @(negedge clk);
        chk("s4_start_in_done_ignored", int'(out_v[0][6]), 0);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        @(negedge clk);
        chk("s4_start_after_done_taken", int'(out_v[0][6]), 1);
        done_t = -1;
        for (int t = 1; t < 100; t++) begin
            @(negedge clk);
            if (out_v[0][5]) begin
                done_t = t;
                break;
            end
        end
        chk("s4_second_done_cycle", done_t, 35);

        // Asynchronous reset in the middle of bit 7
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        rises = 0;
        p = '0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            o = out_v[0];
            if (o[4] && !p[4]) rises++;
            p = o;
            if (rises == 7 && !o[4]) break;
        end
        chk("s5_reached_bit7", rises, 7);
        #1 rst = 1'b1;
        #1 chk("s5_async_reset_outputs", int'(out_v[0]), 0);
        @(negedge clk);
        #1 rst = 1'b0;
        cnt = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (out_v[0][3] || out_v[0][5]) cnt++;
        end
        chk("s5_no_load_after_reset", cnt, 0);
        run_xfer(0, 1'b0, rises, ones1, ones2, s1, s2, done_t, load_w, rstn_low, busy_at_done);
        chk("s5_rerun_data1", s1, 32'h4321);
        chk("s5_rerun_data2", s2, 32'h0056);
        chk("s5_rerun_done_cycle", done_t, 35);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
